// File: rtl/csr_access_unit_if.sv
// csr_access_unit_if: request/response handshake between the execute stage and the CSR access
// unit, plus the unit's read-data / write-enable / write-data bus to the CSR bank.
//   master: the environment (execute stage issuing requests, CSR bank answering reads).
//   slave:  the CSR access unit.

interface csr_access_unit_if #(
   parameter int unsigned Width = 32
);

   // Request from the execute stage.
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [11:0]      req_addr;
   logic [Width-1:0] req_operand;
   logic             req_rs1_zero;
   logic             req_rd_zero;

   // CSR bank access.
   logic [11:0]      csr_addr;
   logic             csr_rd_en;
   logic [Width-1:0] csr_rdata;
   logic             csr_exists;
   logic             csr_wr_en;
   logic [Width-1:0] csr_wr_data;

   // Response back to the execute stage.
   logic             rsp_valid;
   logic             rsp_ready;
   logic [Width-1:0] rsp_rdata;
   logic             rsp_illegal;

   modport master (
      output req_valid, req_op, req_addr, req_operand, req_rs1_zero, req_rd_zero,
      output csr_rdata, csr_exists,
      output rsp_ready,
      input  req_ready,
      input  csr_addr, csr_rd_en, csr_wr_en, csr_wr_data,
      input  rsp_valid, rsp_rdata, rsp_illegal
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_operand, req_rs1_zero, req_rd_zero,
      input  csr_rdata, csr_exists,
      input  rsp_ready,
      output req_ready,
      output csr_addr, csr_rd_en, csr_wr_en, csr_wr_data,
      output rsp_valid, rsp_rdata, rsp_illegal
   );

endinterface

// File: rtl/csr_access_unit.sv
// csr_access_unit: runs the Zicsr read-modify-write sequence (CSRRW/CSRRS/CSRRC and immediate
// forms) against the CSR bank. One request at a time: IDLE -> READ -> WRITE -> RESP -> IDLE.
// All bank strobes and response fields are registered, so they never glitch.

module csr_access_unit #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [1:0]       priv_i,
   csr_access_unit_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWrite,
      StResp
   } state_e;

   localparam logic [1:0] OpRsvd = 2'b00;
   localparam logic [1:0] OpRw   = 2'b01;
   localparam logic [1:0] OpRs   = 2'b10;
   localparam logic [1:0] OpRc   = 2'b11;

   state_e           state_q;

   // Latched request.
   logic [1:0]       op_q;
   logic [11:0]      addr_q;
   logic [Width-1:0] operand_q;
   logic             rs1_zero_q;

   // Outcome of the READ cycle, carried to the response.
   logic [Width-1:0] old_q;
   logic             illegal_q;

   // Registered outputs.
   logic [11:0]      csr_addr_q;
   logic             csr_rd_en_q;
   logic             csr_wr_en_q;
   logic [Width-1:0] csr_wr_data_q;
   logic             rsp_valid_q;
   logic [Width-1:0] rsp_rdata_q;
   logic             rsp_illegal_q;

   logic             wr_needed;
   logic             illegal;
   logic             write_ok;
   logic [Width-1:0] new_val;

   // Legality and new value, evaluated on the bank data presented during READ.
   always_comb begin
      wr_needed = (op_q == OpRw) || !rs1_zero_q;
      illegal   = (op_q == OpRsvd)
                  || !bus.csr_exists
                  || (priv_i < addr_q[9:8])
                  || (wr_needed && (addr_q[11:10] == 2'b11));
      write_ok  = wr_needed && !illegal;
      unique case (op_q)
         OpRs:    new_val = bus.csr_rdata | operand_q;
         OpRc:    new_val = bus.csr_rdata & ~operand_q;
         default: new_val = operand_q;
      endcase
   end

   // Sequencer with registered bank strobes and response.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q       <= StIdle;
         op_q          <= OpRsvd;
         addr_q        <= '0;
         operand_q     <= '0;
         rs1_zero_q    <= 1'b0;
         old_q         <= '0;
         illegal_q     <= 1'b0;
         csr_addr_q    <= '0;
         csr_rd_en_q   <= 1'b0;
         csr_wr_en_q   <= 1'b0;
         csr_wr_data_q <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_illegal_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  state_q     <= StRead;
                  op_q        <= bus.req_op;
                  addr_q      <= bus.req_addr;
                  operand_q   <= bus.req_operand;
                  rs1_zero_q  <= bus.req_rs1_zero;
                  csr_addr_q  <= bus.req_addr;
                  // CSRRW to x0 must not trigger read side effects.
                  csr_rd_en_q <= !((bus.req_op == OpRw) && bus.req_rd_zero);
               end
            end
            StRead: begin
               state_q       <= StWrite;
               csr_rd_en_q   <= 1'b0;
               csr_wr_en_q   <= write_ok;
               csr_wr_data_q <= write_ok ? new_val : '0;
               // A suppressed read or an illegal access returns zero.
               old_q         <= (illegal || !csr_rd_en_q) ? '0 : bus.csr_rdata;
               illegal_q     <= illegal;
            end
            StWrite: begin
               state_q       <= StResp;
               csr_wr_en_q   <= 1'b0;
               rsp_valid_q   <= 1'b1;
               rsp_rdata_q   <= old_q;
               rsp_illegal_q <= illegal_q;
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  state_q       <= StIdle;
                  rsp_valid_q   <= 1'b0;
                  rsp_rdata_q   <= '0;
                  rsp_illegal_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.req_ready   = (state_q == StIdle);
   assign bus.csr_addr    = csr_addr_q;
   assign bus.csr_rd_en   = csr_rd_en_q;
   assign bus.csr_wr_en   = csr_wr_en_q;
   assign bus.csr_wr_data = csr_wr_data_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed vectors with hand-computed results, a transaction-level model
// that predicts every cycle's outputs, and one compare process on the falling clock edge.

module tb_csr_access_unit;

   localparam int unsigned Width = 32;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        ill;
      logic [31:0] wd;
      logic [31:0] rdata;
   } exp_t;

   typedef struct packed {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] opnd;
      logic        rs1z;
      logic        rdz;
      logic [1:0]  priv;
      logic [31:0] old;
      logic        exists;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_wd;
      logic [31:0] e_rdata;
      logic        e_ill;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic [1:0]  priv_i;
   logic [31:0] bank_old;
   logic        bank_exists;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: mdl_phase is the current cycle's position in the sequence
   // (0 idle, 1 read, 2 write, 3 response) once the rising edge has passed.
   int          mdl_phase = 0;
   bit          fresh = 1'b1;
   exp_t        cur;
   logic [11:0] cur_addr;

   logic        obs_rd;
   logic        obs_wr;
   logic [31:0] obs_wdata;
   logic [31:0] obs_rdata;
   logic        obs_ill;

   vec_t vec [15];

   csr_access_unit_if #(.Width(Width)) bus ();

   assign bus.csr_rdata  = bank_old;
   assign bus.csr_exists = bank_exists;

   csr_access_unit #(.Width(Width)) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .priv_i (priv_i),
      .bus    (bus)
   );

   initial forever #5 clk_i = ~clk_i;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural outcome of one Zicsr access.
   function automatic exp_t model(input logic [1:0] op, input logic [11:0] a,
                                  input logic [31:0] opnd, input logic rs1z, input logic rdz,
                                  input logic [1:0] priv, input logic [31:0] old,
                                  input logic exists);
      exp_t e;
      logic writes;
      e.rd   = !(op == 2'b01 && rdz);
      writes = (op == 2'b01) || !rs1z;
      e.ill  = (op == 2'b00) || !exists || (priv < a[9:8]) || (writes && a[11:10] == 2'b11);
      e.wr   = writes && !e.ill;
      if (op == 2'b10)      e.wd = old | opnd;
      else if (op == 2'b11) e.wd = old & ~opnd;
      else                  e.wd = opnd;
      e.rdata = (e.ill || !e.rd) ? 32'h0 : old;
      return e;
   endfunction

   // Per-cycle compare against the model, then advance the model to the next cycle.
   initial forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
         chk1("rst_req_ready", bus.req_ready, 1'b1);
         chk1("rst_rd_en", bus.csr_rd_en, 1'b0);
         chk1("rst_wr_en", bus.csr_wr_en, 1'b0);
         chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
         chk1("rst_rsp_illegal", bus.rsp_illegal, 1'b0);
         chk32("rst_csr_addr", {20'h0, bus.csr_addr}, 32'h0);
         chk32("rst_wr_data", bus.csr_wr_data, 32'h0);
         chk32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
         mdl_phase = 0;
         fresh     = 1'b1;
      end else begin
         case (mdl_phase)
            0: begin
               chk1("idle_req_ready", bus.req_ready, 1'b1);
               chk1("idle_rd_en", bus.csr_rd_en, 1'b0);
               chk1("idle_wr_en", bus.csr_wr_en, 1'b0);
               chk1("idle_rsp_valid", bus.rsp_valid, 1'b0);
               if (fresh) begin
                  chk32("idle_csr_addr", {20'h0, bus.csr_addr}, 32'h0);
                  chk32("idle_wr_data", bus.csr_wr_data, 32'h0);
                  chk32("idle_rsp_rdata", bus.rsp_rdata, 32'h0);
                  chk1("idle_rsp_illegal", bus.rsp_illegal, 1'b0);
               end
            end
            1: begin
               chk1("read_req_ready", bus.req_ready, 1'b0);
               chk1("read_rd_en", bus.csr_rd_en, cur.rd);
               chk1("read_wr_en", bus.csr_wr_en, 1'b0);
               chk1("read_rsp_valid", bus.rsp_valid, 1'b0);
               chk32("read_csr_addr", {20'h0, bus.csr_addr}, {20'h0, cur_addr});
               obs_rd = bus.csr_rd_en;
            end
            2: begin
               chk1("write_req_ready", bus.req_ready, 1'b0);
               chk1("write_rd_en", bus.csr_rd_en, 1'b0);
               chk1("write_wr_en", bus.csr_wr_en, cur.wr);
               chk1("write_rsp_valid", bus.rsp_valid, 1'b0);
               chk32("write_csr_addr", {20'h0, bus.csr_addr}, {20'h0, cur_addr});
               if (cur.wr) chk32("write_wr_data", bus.csr_wr_data, cur.wd);
               obs_wr    = bus.csr_wr_en;
               obs_wdata = bus.csr_wr_data;
            end
            default: begin
               chk1("resp_req_ready", bus.req_ready, 1'b0);
               chk1("resp_rd_en", bus.csr_rd_en, 1'b0);
               chk1("resp_wr_en", bus.csr_wr_en, 1'b0);
               chk1("resp_rsp_valid", bus.rsp_valid, 1'b1);
               chk32("resp_rdata", bus.rsp_rdata, cur.rdata);
               chk1("resp_illegal", bus.rsp_illegal, cur.ill);
               obs_rdata = bus.rsp_rdata;
               obs_ill   = bus.rsp_illegal;
            end
         endcase
         case (mdl_phase)
            0: begin
               if (bus.req_valid) begin
                  cur = model(bus.req_op, bus.req_addr, bus.req_operand, bus.req_rs1_zero,
                              bus.req_rd_zero, priv_i, bank_old, bank_exists);
                  cur_addr  = bus.req_addr;
                  fresh     = 1'b0;
                  mdl_phase = 1;
               end
            end
            1: mdl_phase = 2;
            2: mdl_phase = 3;
            default: if (bus.rsp_ready) mdl_phase = 0;
         endcase
      end
   end

   task automatic present(input int i);
      bus.req_op       = vec[i].op;
      bus.req_addr     = vec[i].addr;
      bus.req_operand  = vec[i].opnd;
      bus.req_rs1_zero = vec[i].rs1z;
      bus.req_rd_zero  = vec[i].rdz;
      priv_i           = vec[i].priv;
      bank_old         = vec[i].old;
      bank_exists      = vec[i].exists;
      bus.req_valid    = 1'b1;
   endtask

   // Called just after a rising edge; waits (bounded) until the current cycle is phase ph.
   task automatic wait_phase(input int ph, input string tag);
      int n = 0;
      while (mdl_phase != ph && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (mdl_phase != ph) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: phase %0d, required %0d", tag, mdl_phase, ph);
      end
   endtask

   // One transaction; hold = response cycles with rsp_ready low, nxt = request shown meanwhile.
   task automatic run(input int i, input int hold, input int nxt);
      present(i);
      wait_phase(1, "accept");
      bus.req_valid = 1'b0;
      bus.rsp_ready = (hold == 0);
      wait_phase(3, "resp");
      if (nxt >= 0) present(nxt);
      repeat (hold) begin
         @(posedge clk_i);
         #1;
      end
      bus.rsp_ready = 1'b1;
      wait_phase(0, "idle");
      chk1($sformatf("v%0d_rd_en", i), obs_rd, vec[i].e_rd);
      chk1($sformatf("v%0d_wr_en", i), obs_wr, vec[i].e_wr);
      if (vec[i].e_wr) chk32($sformatf("v%0d_wr_data", i), obs_wdata, vec[i].e_wd);
      chk32($sformatf("v%0d_rsp_rdata", i), obs_rdata, vec[i].e_rdata);
      chk1($sformatf("v%0d_rsp_illegal", i), obs_ill, vec[i].e_ill);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      //          op     addr     operand       rs1z  rdz   priv   old           ex    rd    wr    wdata         rdata         ill
      vec[0]  = '{2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 1'b0, 2'b11, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0};
      vec[1]  = '{2'b10, 12'h340, 32'h0000000F, 1'b0, 1'b0, 2'b11, 32'h000000F0, 1'b1, 1'b1, 1'b1, 32'h000000FF, 32'h000000F0, 1'b0};
      vec[2]  = '{2'b11, 12'h340, 32'h000000F0, 1'b0, 1'b0, 2'b11, 32'h000000FF, 1'b1, 1'b1, 1'b1, 32'h0000000F, 32'h000000FF, 1'b0};
      vec[3]  = '{2'b10, 12'h340, 32'h00000000, 1'b1, 1'b0, 2'b11, 32'h0000000F, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h0000000F, 1'b0};
      vec[4]  = '{2'b01, 12'h340, 32'hCAFE0001, 1'b0, 1'b1, 2'b11, 32'h00000055, 1'b1, 1'b0, 1'b1, 32'hCAFE0001, 32'h00000000, 1'b0};
      vec[5]  = '{2'b01, 12'hF14, 32'h00000001, 1'b0, 1'b0, 2'b11, 32'h00000003, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
      vec[6]  = '{2'b10, 12'hF14, 32'h00000000, 1'b1, 1'b0, 2'b11, 32'h00000007, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000007, 1'b0};
      vec[7]  = '{2'b01, 12'h300, 32'h00000008, 1'b0, 1'b0, 2'b00, 32'h00001800, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
      vec[8]  = '{2'b01, 12'h340, 32'h00000009, 1'b0, 1'b0, 2'b11, 32'h0000ABCD, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
      vec[9]  = '{2'b00, 12'h340, 32'h00000009, 1'b0, 1'b0, 2'b11, 32'h0000ABCD, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
      vec[10] = '{2'b11, 12'h100, 32'hFFFF0000, 1'b0, 1'b0, 2'b01, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h00005678, 32'h12345678, 1'b0};
      vec[11] = '{2'b10, 12'h340, 32'h00000100, 1'b0, 1'b0, 2'b11, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h00000101, 32'h00000001, 1'b0};
      vec[12] = '{2'b01, 12'h341, 32'hA5A5A5A5, 1'b0, 1'b0, 2'b11, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h80000000, 1'b0};
      vec[13] = '{2'b01, 12'h340, 32'h11111111, 1'b0, 1'b0, 2'b11, 32'h00000002, 1'b1, 1'b1, 1'b1, 32'h11111111, 32'h00000002, 1'b0};
      vec[14] = '{2'b10, 12'hC00, 32'h00000000, 1'b1, 1'b0, 2'b00, 32'h00001234, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00001234, 1'b0};

      rstn_i        = 1'b0;
      bus.rsp_ready = 1'b1;
      // A request held during reset must not be taken.
      present(0);
      repeat (3) @(posedge clk_i);
      #1;
      bus.req_valid = 1'b0;
      rstn_i        = 1'b1;
      @(posedge clk_i);
      #1;

      for (int i = 0; i <= 10; i++) run(i, 0, -1);

      // Backpressure: response held 5 cycles while the next request waits.
      run(11, 5, 12);
      run(12, 0, -1);

      // Reset in the WRITE cycle drops the write and the response.
      present(13);
      wait_phase(1, "accept");
      bus.req_valid = 1'b0;
      @(posedge clk_i);
      #2;
      chk1("pre_rst_wr_en", bus.csr_wr_en, 1'b1);
      chk32("pre_rst_wr_data", bus.csr_wr_data, 32'h11111111);
      rstn_i = 1'b0;
      #1;
      chk1("rst_wr_en_drop", bus.csr_wr_en, 1'b0);
      chk1("rst_async_req_ready", bus.req_ready, 1'b1);
      chk32("rst_async_wr_data", bus.csr_wr_data, 32'h0);
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;

      run(14, 0, -1);
      run(0, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Executes the read-modify-write sequence of the Zicsr instructions (CSRRW/CSRRS/CSRRC and their immediate forms) against the core's CSR bank. The core's execute stage issues one request at a time through a valid/ready handshake. The unit reads the addressed CSR, checks access legality, writes the bank's per-register write ports, and returns the old value or an illegal-instruction flag. It is the initiator side of the CSR bank's read-data / write-enable / write-data interface.

## Interface
Parameters:
- Width, 32, CSR data width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request; high exactly in IDLE.
- req_op_i  in  2  01 = RW, 10 = RS, 11 = RC, 00 = reserved (illegal).
- req_addr_i  in  12  CSR address.
- req_operand_i  in  Width  rs1 value, or zero-extended zimm.
- req_rs1_zero_i  in  1  rs1/zimm field is zero.
- req_rd_zero_i  in  1  rd is x0.
- priv_i  in  2  current privilege level (00 U, 01 S, 11 M).
- csr_addr_o  out  12  address to the bank.
- csr_rd_en_o  out  1  read strobe; the bank may apply read side effects.
- csr_rdata_i  in  Width  bank read data, combinational on csr_addr_o.
- csr_exists_i  in  1  address is implemented, combinational on csr_addr_o.
- csr_wr_en_o  out  1  one-cycle write strobe to the selected register.
- csr_wr_data_o  out  Width  value to write.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer accepts the response.
- rsp_rdata_o  out  Width  old CSR value; 0 if not read or illegal.
- rsp_illegal_o  out  1  raise illegal-instruction exception.

## Operation
- FSM states and transitions:
  - IDLE -> READ on req_valid_i && req_ready_o. The request is latched on that edge.
  - READ -> WRITE unconditionally.
  - WRITE -> RESP unconditionally.
  - RESP -> IDLE on rsp_ready_i.
- READ:
  - csr_addr_o = latched address.
  - csr_rd_en_o = !(op==RW && rd_zero).
  - csr_rdata_i and csr_exists_i are captured on the closing edge.
- Write decision:
  - wr_needed = (op==RW) || !rs1_zero.
  - The RS/RC old value is read even when rd is zero.
- Illegal when any of the following holds:
  - op==00;
  - !exists (captured);
  - priv_i < addr[9:8];
  - wr_needed && addr[11:10]==2'b11 (read-only space).
- New value:
  - RW: operand.
  - RS: old | operand.
  - RC: old & ~operand.
  - All Width bits are computed; no truncation.
- WRITE:
  - csr_wr_en_o = wr_needed && !illegal, for exactly one cycle.
  - csr_addr_o holds the latched address.
  - csr_wr_data_o = new value.
- RESP:
  - rsp_valid_o = 1 and is held until rsp_ready_i is sampled high.
  - rsp_rdata_o / rsp_illegal_o are stable while valid.
  - rsp_rdata_o = 0 when illegal or when the read was suppressed.
- No write ever occurs for an illegal request.
- At most one request is in flight; req_ready_o = 0 outside IDLE.

## Timing
- Reset (rstn_i low), asynchronous:
  - state = IDLE;
  - csr_rd_en_o, csr_wr_en_o, rsp_valid_o, rsp_illegal_o = 0;
  - csr_addr_o, csr_wr_data_o, rsp_rdata_o = 0;
  - req_ready_o = 1, but no request is accepted while rstn_i is low.
- Accept on edge T:
  - READ in cycle T+1;
  - write strobe in cycle T+2;
  - rsp_valid_o from cycle T+3.
- Minimum spacing between accepted requests is 4 cycles: the response is consumed at T+3, giving IDLE at T+4.
- csr_wr_en_o and csr_rd_en_o are registered or state-decoded; they never glitch outside READ/WRITE.
- Reset asserted mid-sequence:
  - immediate return to IDLE with all strobes low;
  - a pending write is dropped;
  - no response is produced.
- Timing of rsp_ready_i:
  - high on the first RESP cycle: the response lasts exactly one cycle.
  - low: the response persists and the inputs are ignored.

## Test plan
- RW, addr 0x340, operand 0xDEADBEEF, old 0x12345678, priv M -> read at T+1; write 0xDEADBEEF at T+2; rsp_rdata 0x12345678, illegal 0 at T+3.
- RS with operand 0x0000000F, old 0x000000F0 -> write 0x000000FF. Then RC with operand 0x000000F0 -> write 0x0000000F. Repeat RS with rs1_zero=1 -> no csr_wr_en_o, rdata returned.
- RW with rd_zero=1 -> csr_rd_en_o stays 0, write occurs, rsp_rdata 0.
- Illegal cases, each giving rsp_illegal 1, no write, rdata 0:
  - addr 0xF14 RW;
  - addr 0x300 with priv_i=00;
  - csr_exists_i=0;
  - op=00.
- Backpressure: hold rsp_ready_i low 5 cycles -> rsp_valid and data stable; req_ready_o 0; a new req_valid_i is not accepted until the cycle after the handshake.
- Deassert rstn_i during WRITE -> csr_wr_en_o drops immediately; after release the unit is in IDLE with all outputs at reset values.
